// File: rtl/yuv422_to_444_pkg.sv
// Shared constants for the 4:2:2 to 4:4:4 chroma upsampler.
// Pixel phase encoding and neutral chroma helper.
package yuv422_to_444_pkg;

   localparam int LATENCY_422 = 2;

   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } phase_e;

   function automatic int unsigned neutral_chroma(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

endpackage

// File: rtl/yuv422_to_444_sync_delay.sv
// N-flop shift line for sync signals.
// Synchronous active-high reset.
module sync_delay #(
   parameter int N = 2
) (
   input  logic pclk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [N-1:0] sr;

   always_ff @(posedge pclk) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < N; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[N-1];

endmodule

// File: rtl/yuv422_to_444.sv
// YUV 4:2:2 to 4:4:4 upsampler by chroma replication.
// Two-cycle pipeline in 4:2:2 mode, combinational bypass otherwise.
module yuv422_to_444
   import yuv422_to_444_pkg::*;
#(
   parameter int BITS   = 8,
   parameter int WIDTH  = 1280,
   parameter int HEIGHT = 960
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic            YUV422TO444,
   input  logic            in_href,
   input  logic            in_vsync,
   input  logic [BITS-1:0] in_y,
   input  logic [BITS-1:0] in_c,
   input  logic [BITS-1:0] in_v,
   output logic            out_href,
   output logic            out_vsync,
   output logic [BITS-1:0] out_y,
   output logic [BITS-1:0] out_u,
   output logic [BITS-1:0] out_v
);

   localparam logic [BITS-1:0] NEUTRAL = BITS'(neutral_chroma(BITS));

   if (WIDTH < 1 || HEIGHT < 1) begin : g_bad_geom
      $error("yuv422_to_444: WIDTH and HEIGHT must be positive");
   end

   logic            discard_q;
   logic            href_ok;
   phase_e          ph_q;
   logic            s1_href;
   phase_e          s1_ph;
   logic [BITS-1:0] s1_y;
   logic [BITS-1:0] s1_c;
   logic [BITS-1:0] u_hold;
   logic [BITS-1:0] last_v;
   logic [BITS-1:0] o_y;
   logic [BITS-1:0] o_u;
   logic [BITS-1:0] o_v;
   logic            href_d;
   logic            vsync_d;

   // A line cut by reset stays suppressed until href drops.
   assign href_ok = in_href & ~discard_q;

   always_ff @(posedge pclk) begin
      if (rst) begin
         discard_q <= 1'b1;
         ph_q      <= EVEN;
         s1_href   <= 1'b0;
         s1_ph     <= EVEN;
         s1_y      <= '0;
         s1_c      <= '0;
         u_hold    <= '0;
         last_v    <= NEUTRAL;
         o_y       <= '0;
         o_u       <= '0;
         o_v       <= '0;
      end else begin
         if (!in_href) discard_q <= 1'b0;
         ph_q    <= href_ok ? ((ph_q == EVEN) ? ODD : EVEN) : EVEN;
         s1_href <= href_ok;
         s1_ph   <= ph_q;
         s1_y    <= in_y;
         s1_c    <= in_c;
         if (!href_ok) begin
            last_v <= NEUTRAL;
         end else if (ph_q == ODD) begin
            last_v <= in_c;
         end
         unique case (1'b1)
            !s1_href: begin
               o_y <= '0;
               o_u <= '0;
               o_v <= '0;
            end
            s1_href && (s1_ph == EVEN): begin
               o_y    <= s1_y;
               o_u    <= s1_c;
               o_v    <= href_ok ? in_c : last_v;
               u_hold <= s1_c;
            end
            s1_href && (s1_ph == ODD): begin
               o_y <= s1_y;
               o_u <= u_hold;
               o_v <= s1_c;
            end
            default: begin
               o_y <= '0;
               o_u <= '0;
               o_v <= '0;
            end
         endcase
      end
   end

   sync_delay #(.N(LATENCY_422)) u_href_dly (
      .pclk (pclk),
      .rst  (rst),
      .din  (href_ok),
      .dout (href_d)
   );

   sync_delay #(.N(LATENCY_422)) u_vsync_dly (
      .pclk (pclk),
      .rst  (rst),
      .din  (in_vsync),
      .dout (vsync_d)
   );

   always_comb begin
      out_href  = href_d;
      out_vsync = vsync_d;
      out_y     = o_y;
      out_u     = o_u;
      out_v     = o_v;
      if (!YUV422TO444) begin
         out_href  = in_href;
         out_vsync = in_vsync;
         out_y     = in_href ? in_y : '0;
         out_u     = in_href ? in_c : '0;
         out_v     = in_href ? in_v : '0;
      end
   end

endmodule

// File: tb/tb_yuv422_to_444.sv
// Scoreboard bench for yuv422_to_444.
// Expected pixels queued at drive time, popped on out_href.
module tb_yuv422_to_444;

   typedef struct {
      int         cyc;
      logic [7:0] y;
      logic [7:0] u;
      logic [7:0] v;
   } exp_t;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       mode = 1'b1;
   logic       in_href = 1'b0;
   logic       in_vsync = 1'b0;
   logic [7:0] in_y = '0;
   logic [7:0] in_c = '0;
   logic [7:0] in_v = '0;
   logic       out_href;
   logic       out_vsync;
   logic [7:0] out_y;
   logic [7:0] out_u;
   logic [7:0] out_v;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   logic rst_q = 1'b0;
   logic vhist [0:4095];
   exp_t sbq [$];

   yuv422_to_444 #(.BITS(8), .WIDTH(1280), .HEIGHT(960)) dut (
      .pclk        (pclk),
      .rst         (rst),
      .YUV422TO444 (mode),
      .in_href     (in_href),
      .in_vsync    (in_vsync),
      .in_y        (in_y),
      .in_c        (in_c),
      .in_v        (in_v),
      .out_href    (out_href),
      .out_vsync   (out_vsync),
      .out_y       (out_y),
      .out_u       (out_u),
      .out_v       (out_v)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc %0d got %0h exp %0h", tag, cyc, got, exp);
      end
   endtask

   always @(negedge pclk) begin
      exp_t e;
      vhist[cyc[11:0]] = in_vsync;
      if (!mode) begin
         check("byp_href", 32'(out_href), 32'(in_href));
         check("byp_vs", 32'(out_vsync), 32'(in_vsync));
         check("byp_data", {8'h0, out_y, out_u, out_v},
               in_href ? {8'h0, in_y, in_c, in_v} : 32'h0);
      end else begin
         if (rst_q) check("rst_href", 32'(out_href), 32'h0);
         if (cyc >= 2)
            check("vsync", 32'(out_vsync), 32'(vhist[12'(cyc - 2)]));
         if (out_href) begin
            if (sbq.size() == 0) begin
               check("orphan", 32'(out_href), 32'h0);
            end else begin
               e = sbq.pop_front();
               check("lat", 32'(cyc), 32'(e.cyc));
               check("pix", {8'h0, out_y, out_u, out_v},
                     {8'h0, e.y, e.u, e.v});
            end
         end else begin
            check("idle", {8'h0, out_y, out_u, out_v}, 32'h0);
         end
      end
   end

   task automatic step(input logic h, input logic vs, input logic [7:0] y,
                       input logic [7:0] c, input logic [7:0] v);
      @(posedge pclk);
      #1;
      in_href  = h;
      in_vsync = vs;
      in_y     = y;
      in_c     = c;
      in_v     = v;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h5A, 8'hA5, 8'h3C);
   endtask

   function automatic exp_t pixel(input int n, input int i, input int at,
                                  input logic [63:0] ys,
                                  input logic [63:0] cs);
      exp_t e;
      e.cyc = at;
      e.y   = ys[8*i +: 8];
      if (i % 2 == 0) begin
         e.u = cs[8*i +: 8];
         if (i + 1 < n)  e.v = cs[8*(i+1) +: 8];
         else if (i > 0) e.v = cs[8*(i-1) +: 8];
         else            e.v = 8'h80;
      end else begin
         e.u = cs[8*(i-1) +: 8];
         e.v = cs[8*i +: 8];
      end
      return e;
   endfunction

   task automatic send_line(input int n, input logic [63:0] ys,
                            input logic [63:0] cs);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, ys[8*i +: 8], cs[8*i +: 8], 8'hEE);
         sbq.push_back(pixel(n, i, cyc + 2, ys, cs));
      end
   endtask

   localparam logic [63:0] L1_Y = 64'h0D0C0B0A;
   localparam logic [63:0] L1_C = 64'h81418040;

   initial begin
      idle(3);
      rst = 1'b0;
      idle(2);

      send_line(4, L1_Y, L1_C);
      idle(3);

      send_line(3, 64'h030201, 64'h223020);
      idle(2);
      send_line(1, 64'h05, 64'h11);
      idle(3);

      send_line(4, 64'h24232221, 64'h9C5B9A59);
      idle(1);
      send_line(4, 64'h34333231, 64'h6F2E6D2C);
      idle(3);

      send_line(5, 64'h4544434241, 64'h1190F00FE0);
      idle(3);

      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h0, 8'h0, 8'h0);
      idle(4);

      step(1'b1, 1'b0, 8'h51, 8'h60, 8'hEE);
      sbq.push_back('{cyc + 2, 8'h51, 8'h60, 8'h70});
      step(1'b1, 1'b0, 8'h52, 8'h70, 8'hEE);
      step(1'b1, 1'b0, 8'h53, 8'h61, 8'hEE);
      rst = 1'b1;
      step(1'b1, 1'b0, 8'h54, 8'h71, 8'hEE);
      rst = 1'b0;
      idle(2);
      send_line(4, L1_Y, L1_C);
      idle(3);

      mode = 1'b0;
      step(1'b1, 1'b0, 8'h07, 8'h33, 8'h44);
      step(1'b0, 1'b0, 8'h09, 8'h55, 8'h66);
      step(1'b1, 1'b1, 8'h0F, 8'h77, 8'h88);
      idle(3);
      mode = 1'b1;
      idle(3);

      send_line(2, 64'hB2B1, 64'hC2C1);
      idle(4);

      check("drain", 32'(sbq.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/yuv422_to_444.md
YUV422_TO_444 -- requirements
Module: yuv422_to_444

Interface
REQ-001 Parameter BITS, default 8, sample width of every data port.
REQ-002 Parameter WIDTH, default 1280, nominal active pixels per line (informational; no logic depends on it).
REQ-003 Parameter HEIGHT, default 960, nominal lines per frame (informational).
REQ-004 pclk  input  1  pixel clock; the block's only clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous to pclk, active-high.
REQ-006 YUV422TO444  input  1  mode; 1 = upsample a 4:2:2 stream, 0 = 4:4:4 bypass; held stable within a frame.
REQ-007 in_href  input  1  line-valid; one pixel per cycle while high.
REQ-008 in_vsync  input  1  frame sync; delayed only, never interpreted.
REQ-009 in_y  input  BITS  luma.
REQ-010 in_c  input  BITS  chroma; in 4:2:2 mode U on even pixels and V on odd pixels; in bypass mode U.
REQ-011 in_v  input  BITS  V in bypass mode; ignored in 4:2:2 mode.
REQ-012 out_href, out_vsync  output  1 each  delayed syncs.
REQ-013 out_y, out_u, out_v  output  BITS each  4:4:4 pixel.

Function
REQ-014 Pixel phase bit: cleared whenever in_href is low, otherwise toggles each cycle; the first pixel of every line is even (phase 0).
REQ-015 4:2:2 mode: input pair (Y0,U0),(Y1,V0) SHALL produce output pixels (Y0,U0,V0) then (Y1,U0,V0).
REQ-016 4:2:2 mode latency: exactly 2 cycles; in_* sampled in cycle n appear on out_* in cycle n+2. out_href and out_vsync are in_href and in_vsync delayed by 2 flops.
REQ-017 Pipeline stage 1 registers in_y, in_c, phase and in_href.
REQ-018 Output register, stage-1 even pixel: loads y = stage-1 y, u = stage-1 c, v = current in_c (the partner V); it also stores U for the odd pixel.
REQ-019 Output register, stage-1 odd pixel: loads y = stage-1 y, u = stored U, v = stage-1 c.
REQ-020 Odd-length line (in_href falls after an even pixel): that pixel's v SHALL equal the V of the last completed pair on the same line; with no prior pair on the line, v SHALL be 2^(BITS-1).
REQ-021 The last-V register SHALL be cleared to 2^(BITS-1) whenever in_href is low.
REQ-022 Chroma is replicated, never averaged or interpolated; no arithmetic beyond copying, so all widths stay BITS.
REQ-023 4:2:2 mode: out_y, out_u and out_v SHALL be 0 whenever out_href is low.
REQ-024 Bypass mode: out_* SHALL equal in_href, in_vsync, in_y, in_c and in_v combinationally with 0 latency, data forced to 0 while in_href is low. The pipeline keeps running underneath.
REQ-025 Back-to-back lines with a single-cycle in_href low gap SHALL work: phase restarts at 0 and no chroma leaks across the line boundary.

Reset
REQ-026 While rst is high at a pclk edge, every register SHALL clear: phase 0, href/vsync delay lines 0, data registers 0, last-V register 2^(BITS-1).
REQ-027 4:2:2 mode: out_href, out_vsync and all data outputs SHALL read 0 from the first edge of reset. Bypass outputs follow inputs per REQ-024.
REQ-028 Reset asserted mid-line: the partial line is discarded. After release, output resumes with the next in_href rising edge, at phase 0.

Structure
REQ-029 A shared package holds LATENCY_422 = 2, the phase encoding (EVEN = 0, ODD = 1) and the neutral chroma constant 2^(BITS-1).
REQ-030 One sub-module is natural: sync_delay, a parameterised N-flop shift line with synchronous active-high reset, used for href and vsync.

Verification
REQ-031 4:2:2 mode, BITS=8, line pixels (10,0x40),(11,0x80),(12,0x41),(13,0x81) -> from cycle 2: (10,0x40,0x80),(11,0x40,0x80),(12,0x41,0x81),(13,0x41,0x81), with out_href high exactly 4 cycles.
REQ-032 3-pixel line (1,0x20),(2,0x30),(3,0x22) -> third output is (3,0x22,0x30). 1-pixel line (5,0x11) -> (5,0x11,0x80).
REQ-033 Two 4-pixel lines separated by 1 idle cycle -> second line restarts at phase 0 with its own chroma; all outputs are 0 in the gap cycle.
REQ-034 rst pulsed high for 1 cycle after pixel 2 of a line -> outputs 0 starting at the next edge; the following line reproduces REQ-031 exactly.
REQ-035 Bypass mode, input (7,0x33,0x44) with href high -> same cycle out = (7,0x33,0x44); with href low, out data = 0.
REQ-036 in_vsync pulse of 3 cycles in 4:2:2 mode -> out_vsync is the same 3-cycle pulse delayed by 2 cycles.
